// File: rtl/e_mdu_ctrl.sv
// rtl/e_mdu_ctrl.sv - E-stage multiply/divide unit controller with HI/LO registers (optional MDU_MADD_EN adds madd/msub)
module e_mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int CMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  // How the shadow value is folded into {HI,LO} at commit time.
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            launch, commit;
  logic            is_mul_op, is_div_op;

  logic [31:0]     sh_hi, sh_lo;
  acc_t            sh_acc;
  logic            sh_skip;

  logic [63:0]     prod_s, prod_u;
  logic            div_signed, q_neg;
  logic [31:0]     abs_a, abs_b, uq, ur, quo, rem;
  logic [63:0]     hilo, shadow, hilo_add, hilo_sub;

  // Decode which launch class the current opcode belongs to.
  always_comb begin
    is_mul_op = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul_op = is_mul_op || (MDUOp == OP_MADD) || (MDUOp == OP_MSUB);
`endif
    is_div_op = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  end

  // State and cycle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: launch from IDLE, count down, commit on the last busy cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    launch   = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (Start && is_mul_op) begin
          state_nx = MUL;
          cnt_nx   = CW'(MUL_CYCLES);
          launch   = 1'b1;
        end else if (Start && is_div_op) begin
          state_nx = DIV;
          cnt_nx   = CW'(DIV_CYCLES);
          launch   = 1'b1;
        end
      end
      MUL, DIV: begin
        if (cnt <= CW'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign Busy = (state != IDLE);

  // Arithmetic on the live operands; only sampled into the shadow at launch.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};

    // One unsigned divider serves both div and divu via sign-magnitude.
    div_signed = (MDUOp == OP_DIV);
    abs_a      = (div_signed && A[31]) ? (32'd0 - A) : A;
    abs_b      = (div_signed && B[31]) ? (32'd0 - B) : B;
    if (abs_b == 32'd0) begin
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
    q_neg = div_signed && (A[31] ^ B[31]);
    quo   = q_neg ? (32'd0 - uq) : uq;
    rem   = (div_signed && A[31]) ? (32'd0 - ur) : ur;

    hilo     = {HI, LO};
    shadow   = {sh_hi, sh_lo};
    hilo_add = hilo + shadow;
    hilo_sub = hilo - shadow;
  end

  // Shadow result capture at launch; isolates the result from later A/B changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_hi   <= '0;
      sh_lo   <= '0;
      sh_acc  <= ACC_SET;
      sh_skip <= 1'b0;
    end else if (launch) begin
      sh_acc  <= ACC_SET;
      sh_skip <= 1'b0;
      case (MDUOp)
        OP_MULT:  {sh_hi, sh_lo} <= prod_s;
        OP_MULTU: {sh_hi, sh_lo} <= prod_u;
        OP_DIV, OP_DIVU: begin
          sh_hi   <= rem;
          sh_lo   <= quo;
          sh_skip <= (B == 32'd0);
        end
`ifdef MDU_MADD_EN
        OP_MADD: begin
          {sh_hi, sh_lo} <= prod_s;
          sh_acc         <= ACC_ADD;
        end
        OP_MSUB: begin
          {sh_hi, sh_lo} <= prod_s;
          sh_acc         <= ACC_SUB;
        end
`endif
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: commit of in-flight result, or mthi/mtlo while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      if (!sh_skip) begin
        case (sh_acc)
          ACC_ADD: {HI, LO} <= hilo_add;
          ACC_SUB: {HI, LO} <= hilo_sub;
          default: {HI, LO} <= shadow;
        endcase
      end
    end else if (state == IDLE && !launch) begin
      if (MDUOp == OP_MTHI) HI <= A;
      if (MDUOp == OP_MTLO) LO <= A;
    end
  end

  // Read port for mfhi/mflo; no bypass of in-flight results.
  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == OP_MFHI) MDUOut = HI;
    else if (MDUOp == OP_MFLO) MDUOut = LO;
  end

endmodule

// File: doc/e_mdu_ctrl.md
E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, number of Busy cycles for mult/multu (and madd/msub when compiled in).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, number of Busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle pulse launching a mult/div-class op in the E stage.
REQ-006 SHALL have port MDUOp  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 msub.
REQ-007 SHALL have port A  input  32  rs operand (forwarded).
REQ-008 SHALL have port B  input  32  rt operand (forwarded).
REQ-009 SHALL have port Busy  output  1  high while a launched operation is in flight.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.
REQ-012 SHALL have port MDUOut  output  32  read data: HI when MDUOp=5, LO when MDUOp=6, else 0 (combinational).

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV; Busy = (state != IDLE), registered.
REQ-014 IDLE: Start=1 with MDUOp in {1,2,9,10} SHALL go to MUL and load counter with MUL_CYCLES; MDUOp in {3,4} SHALL go to DIV and load counter with DIV_CYCLES.
REQ-015 At launch the result SHALL be computed from A/B sampled that cycle into internal shadow registers; later A/B changes SHALL not affect it.
REQ-016 mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit product.
REQ-017 div: LO = signed A/B truncated toward zero, HI = signed remainder (sign of A); divu: unsigned quotient/remainder.
REQ-018 Divide by zero SHALL run the full DIV_CYCLES and leave HI and LO unchanged.
REQ-019 In MUL/DIV the counter SHALL decrement each cycle; on the cycle it reaches 1, shadow results SHALL be written to HI/LO and state SHALL return to IDLE, so Busy is high for exactly N cycles starting the cycle after Start.
REQ-020 mthi (7) SHALL write A to HI, mtlo (8) SHALL write A to LO, at the next edge, only when state is IDLE.
REQ-021 Start, mthi or mtlo arriving while Busy=1 SHALL be ignored (the hazard unit stalls the D stage on Busy|Start with an MD instruction, so this is a protocol violation).
REQ-022 Start with MDUOp outside {1,2,3,4,9,10} SHALL be ignored; MDUOp=0 SHALL have no effect.
REQ-023 mfhi/mflo during Busy SHALL return the pre-operation HI/LO (no bypass of in-flight results).
REQ-024 Simultaneous Start and mthi/mtlo cannot occur (single MDUOp); Start takes priority over all other codes.

Reset
REQ-025 reset=1 SHALL asynchronously force state IDLE, counter 0, Busy 0, HI 0, LO 0, shadow registers 0.
REQ-026 reset during MUL/DIV SHALL abort the operation; no result SHALL be committed after reset deasserts.

Configuration
REQ-027 Macro MDU_MADD_EN defined: MDUOp 9 (madd) SHALL commit {HI,LO} + signed A*B and 10 (msub) {HI,LO} - signed A*B, mod 2^64, using the {HI,LO} value at commit time, with MUL_CYCLES latency.
REQ-028 MDU_MADD_EN undefined: MDUOp 9 and 10 SHALL be treated as unknown codes (ignored, Busy stays 0).

Verification
REQ-029 Start, mult, A=0xFFFFFFFF, B=2 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 Start, div, A=-7 (0xFFFFFFF9), B=2 -> Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; div with B=0 after mthi 0x11/mtlo 0x22 -> HI=0x11, LO=0x22 after 10 cycles.
REQ-031 mult launched, then mthi A=0x55 and a second Start during Busy -> both ignored; final HI/LO equal first product; mflo during Busy returns old LO.
REQ-032 reset asserted at cycle 3 of a div -> Busy, HI, LO = 0 immediately, remain 0 after reset release with no Start.
REQ-033 With MDU_MADD_EN: mtlo 10, mthi 0, madd A=3 B=4 -> LO=22, HI=0; msub A=1 B=30 -> {HI,LO}=0xFFFFFFFF_FFFFFFF8; without macro, madd -> Busy stays 0, HI/LO unchanged.
